// File: rtl/eth_st_error_adapter_v2.sv
// rtl/eth_st_error_adapter_v2.sv - Avalon-ST error adapter with packet framing checks and optional statistics
//
// Purpose:
//    Sits between the MAC-side Avalon-ST source and the packet sink. It ORs the
//    multi-bit input error into a single bit and adds framing checks: truncated
//    packets (missing EOP, closed by the next SOP), oversize packets, and orphan
//    beats (beats outside a packet, which are dropped). Every beat passes through
//    a one-beat hold register and then a registered output stage. The hold is
//    needed because a beat's final EOP/error can only be known once its
//    successor arrives.
//
// Optional feature macro: ETH_ST_ERR_STATS_EN
//    Defined     - four saturating statistics counters are built.
//    Not defined - stat_* outputs are tied to zero and no counters exist.
//
// Ports:
//    clk, reset           clock, synchronous active-high reset
//    in_*                 Avalon-ST sink (ready, valid, data, sop, eop, empty, error)
//    out_*                Avalon-ST source (ready, valid, data, sop, eop, empty, error)
//                         out_error: [0] input error, [1] truncated, [2] oversize
//    stat_pkts            packets emitted (counted at EOP handshake)
//    stat_trunc           truncated packets emitted
//    stat_oversize        oversize packets emitted
//    stat_orphan          orphan beats dropped

module eth_st_error_adapter_v2 #(
   parameter int DATA_W        = 32,
   parameter int EMPTY_W       = 2,
   parameter int IN_ERR_W      = 1,
   parameter int MAX_PKT_BEATS = 384,
   parameter int CNT_W         = 16
) (
   input  logic                clk,
   input  logic                reset,
   output logic                in_ready,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_startofpacket,
   input  logic                in_endofpacket,
   input  logic [EMPTY_W-1:0]  in_empty,
   input  logic [IN_ERR_W-1:0] in_error,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_startofpacket,
   output logic                out_endofpacket,
   output logic [EMPTY_W-1:0]  out_empty,
   output logic [2:0]          out_error,
   output logic [CNT_W-1:0]    stat_pkts,
   output logic [CNT_W-1:0]    stat_trunc,
   output logic [CNT_W-1:0]    stat_oversize,
   output logic [CNT_W-1:0]    stat_orphan
);

   // Beat counter saturates one above the legal maximum, which is all that is
   // needed to flag oversize without growing with packet length.
   localparam int              BC_W   = $clog2(MAX_PKT_BEATS + 2);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_PKT_BEATS);
   localparam logic [BC_W-1:0] BC_SAT = BC_W'(MAX_PKT_BEATS + 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic                hold_v_q, hold_v_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic                hold_sop_q, hold_sop_d;
   logic                hold_eop_q, hold_eop_d;
   logic [EMPTY_W-1:0]  hold_empty_q, hold_empty_d;
   logic [2:0]          hold_err_q, hold_err_d;

   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_sop_q, out_sop_d;
   logic                out_eop_q, out_eop_d;
   logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
   logic [2:0]          out_error_q, out_error_d;

   logic [BC_W-1:0]     bcnt_q, bcnt_d;
   logic                acc_in_q, acc_in_d;

   logic                out_free;
   logic                accept;
   logic                beat_err;
   logic                take;
   logic                trunc;
   logic                release_hold;
   logic [BC_W-1:0]     bcnt_inc;
   logic [BC_W-1:0]     bcnt_new;
   logic                acc_new;

   assign out_free = !out_valid_q || out_ready;
   assign in_ready = !hold_v_q || out_free;
   assign accept   = in_valid && in_ready;
   assign beat_err = |in_error;

   always_comb begin
      state_d      = state_q;
      hold_v_d     = hold_v_q;
      hold_data_d  = hold_data_q;
      hold_sop_d   = hold_sop_q;
      hold_eop_d   = hold_eop_q;
      hold_empty_d = hold_empty_q;
      hold_err_d   = hold_err_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      out_empty_d  = out_empty_q;
      out_error_d  = out_error_q;
      bcnt_d       = bcnt_q;
      acc_in_d     = acc_in_q;
      take         = 1'b0;
      trunc        = 1'b0;
      bcnt_inc     = (bcnt_q == BC_SAT) ? BC_SAT : bcnt_q + 1'b1;
      bcnt_new     = bcnt_q;
      acc_new      = acc_in_q;

      // take: accepted beat belongs to a packet and goes into the hold.
      // An accepted beat without SOP while idle is an orphan and is dropped.
      if (accept) begin
         if (in_startofpacket) begin
            take  = 1'b1;
            trunc = (state_q == ST_IN_PKT);
         end else if (state_q == ST_IN_PKT) begin
            take  = 1'b1;
         end
      end

      // A hold beat leaves only once its successor proves it is not the last
      // beat, or when it already carries EOP. When take is set with a full
      // hold, in_ready guaranteed out_free.
      release_hold = hold_v_q && out_free && (hold_eop_q || take);

      if (release_hold) begin
         out_valid_d = 1'b1;
         out_data_d  = hold_data_q;
         out_sop_d   = hold_sop_q;
         if (trunc) begin
            // The held beat is the last one of a packet that never saw EOP.
            out_eop_d   = 1'b1;
            out_empty_d = '0;
            out_error_d = {bcnt_q > BC_MAX, 1'b1, acc_in_q};
         end else begin
            out_eop_d   = hold_eop_q;
            out_empty_d = hold_empty_q;
            out_error_d = hold_err_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (take) begin
         if (in_startofpacket) begin
            bcnt_new = BC_W'(1);
            acc_new  = beat_err;
         end else begin
            bcnt_new = bcnt_inc;
            acc_new  = acc_in_q | beat_err;
         end
         bcnt_d       = bcnt_new;
         acc_in_d     = acc_new;
         hold_v_d     = 1'b1;
         hold_data_d  = in_data;
         hold_sop_d   = in_startofpacket;
         hold_eop_d   = in_endofpacket;
         hold_empty_d = in_empty;
         hold_err_d   = in_endofpacket ? {bcnt_new > BC_MAX, 1'b0, acc_new} : 3'b000;
         state_d      = in_endofpacket ? ST_IDLE : ST_IN_PKT;
      end else if (release_hold) begin
         hold_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hold_v_q     <= 1'b0;
         hold_data_q  <= '0;
         hold_sop_q   <= 1'b0;
         hold_eop_q   <= 1'b0;
         hold_empty_q <= '0;
         hold_err_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_empty_q  <= '0;
         out_error_q  <= '0;
         bcnt_q       <= '0;
         acc_in_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_v_q     <= hold_v_d;
         hold_data_q  <= hold_data_d;
         hold_sop_q   <= hold_sop_d;
         hold_eop_q   <= hold_eop_d;
         hold_empty_q <= hold_empty_d;
         hold_err_q   <= hold_err_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         out_empty_q  <= out_empty_d;
         out_error_q  <= out_error_d;
         bcnt_q       <= bcnt_d;
         acc_in_q     <= acc_in_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_startofpacket = out_sop_q;
   assign out_endofpacket   = out_eop_q;
   assign out_empty         = out_empty_q;
   assign out_error         = out_error_q;

`ifdef ETH_ST_ERR_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stat_pkts_q, stat_pkts_d;
   logic [CNT_W-1:0] stat_trunc_q, stat_trunc_d;
   logic [CNT_W-1:0] stat_oversize_q, stat_oversize_d;
   logic [CNT_W-1:0] stat_orphan_q, stat_orphan_d;
   logic             eop_hs;
   logic             orphan_beat;

   assign eop_hs      = out_valid_q && out_ready && out_eop_q;
   assign orphan_beat = accept && !in_startofpacket && (state_q == ST_IDLE);

   always_comb begin
      stat_pkts_d     = stat_pkts_q;
      stat_trunc_d    = stat_trunc_q;
      stat_oversize_d = stat_oversize_q;
      stat_orphan_d   = stat_orphan_q;
      if (eop_hs && (stat_pkts_q != CNT_MAX)) begin
         stat_pkts_d = stat_pkts_q + 1'b1;
      end
      if (eop_hs && out_error_q[1] && (stat_trunc_q != CNT_MAX)) begin
         stat_trunc_d = stat_trunc_q + 1'b1;
      end
      if (eop_hs && out_error_q[2] && (stat_oversize_q != CNT_MAX)) begin
         stat_oversize_d = stat_oversize_q + 1'b1;
      end
      if (orphan_beat && (stat_orphan_q != CNT_MAX)) begin
         stat_orphan_d = stat_orphan_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_pkts_q     <= '0;
         stat_trunc_q    <= '0;
         stat_oversize_q <= '0;
         stat_orphan_q   <= '0;
      end else begin
         stat_pkts_q     <= stat_pkts_d;
         stat_trunc_q    <= stat_trunc_d;
         stat_oversize_q <= stat_oversize_d;
         stat_orphan_q   <= stat_orphan_d;
      end
   end

   assign stat_pkts     = stat_pkts_q;
   assign stat_trunc    = stat_trunc_q;
   assign stat_oversize = stat_oversize_q;
   assign stat_orphan   = stat_orphan_q;
`else
   assign stat_pkts     = '0;
   assign stat_trunc    = '0;
   assign stat_oversize = '0;
   assign stat_orphan   = '0;
`endif

endmodule

// File: tb/tb_eth_st_error_adapter_v2.sv
// tb/tb_eth_st_error_adapter_v2.sv - self-checking bench for eth_st_error_adapter_v2

module tb_eth_st_error_adapter_v2;

   localparam int DATA_W   = 32;
   localparam int EMPTY_W  = 2;
   localparam int IN_ERR_W = 2;
   localparam int MAX_PKT  = 4;
   localparam int CNT_W    = 4;
   localparam int CNT_TOP  = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_ready;
   logic                in_valid;
   logic [DATA_W-1:0]   in_data;
   logic                in_startofpacket;
   logic                in_endofpacket;
   logic [EMPTY_W-1:0]  in_empty;
   logic [IN_ERR_W-1:0] in_error;
   logic                out_ready;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic                out_startofpacket;
   logic                out_endofpacket;
   logic [EMPTY_W-1:0]  out_empty;
   logic [2:0]          out_error;
   logic [CNT_W-1:0]    stat_pkts;
   logic [CNT_W-1:0]    stat_trunc;
   logic [CNT_W-1:0]    stat_oversize;
   logic [CNT_W-1:0]    stat_orphan;

   always #5 clk = ~clk;

   eth_st_error_adapter_v2 #(
      .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .IN_ERR_W(IN_ERR_W),
      .MAX_PKT_BEATS(MAX_PKT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
      .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_empty(in_empty), .in_error(in_error),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty), .out_error(out_error),
      .stat_pkts(stat_pkts), .stat_trunc(stat_trunc),
      .stat_oversize(stat_oversize), .stat_orphan(stat_orphan)
   );

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic                sop;
      logic                eop;
      logic [EMPTY_W-1:0]  empty;
      logic [IN_ERR_W-1:0] ierr;
   } in_beat_t;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
      logic [2:0]         oerr;
   } out_beat_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: collects each packet's accepted beats and, once the
   // packet closes (EOP or an interrupting SOP), emits its expected output.
   in_beat_t  pkt_q[$];
   in_beat_t  stim_q[$];
   out_beat_t exp_q[$];
   out_beat_t obs_q[$];
   bit        in_pkt;
   int        m_pkts, m_trunc, m_ovs, m_orph;

   function automatic void close_pkt(input bit forced);
      int        n;
      bit        anyerr;
      out_beat_t ob;
      n      = pkt_q.size();
      anyerr = 1'b0;
      foreach (pkt_q[i]) anyerr |= (pkt_q[i].ierr != '0);
      for (int i = 0; i < n; i++) begin
         ob.data  = pkt_q[i].data;
         ob.sop   = pkt_q[i].sop;
         ob.eop   = (i == n - 1);
         ob.empty = (i == n - 1 && forced) ? '0 : pkt_q[i].empty;
         ob.oerr  = (i == n - 1) ? {n > MAX_PKT, forced, anyerr} : 3'b000;
         exp_q.push_back(ob);
      end
      m_pkts++;
      if (forced) m_trunc++;
      if (n > MAX_PKT) m_ovs++;
      pkt_q.delete();
   endfunction

   function automatic void model_accept(input in_beat_t b);
      if (b.sop) begin
         if (in_pkt) close_pkt(1'b1);
         pkt_q.push_back(b);
         in_pkt = 1'b1;
      end else if (!in_pkt) begin
         m_orph++;
         return;
      end else begin
         pkt_q.push_back(b);
      end
      if (b.eop) begin
         close_pkt(1'b0);
         in_pkt = 1'b0;
      end
   endfunction

   function automatic int sat(input int v);
      return (v > CNT_TOP) ? CNT_TOP : v;
   endfunction

   task automatic check_stats(input string tag);
`ifdef ETH_ST_ERR_STATS_EN
      check({tag, "_stat_pkts"},     64'(stat_pkts),     64'(sat(m_pkts)));
      check({tag, "_stat_trunc"},    64'(stat_trunc),    64'(sat(m_trunc)));
      check({tag, "_stat_oversize"}, 64'(stat_oversize), 64'(sat(m_ovs)));
      check({tag, "_stat_orphan"},   64'(stat_orphan),   64'(sat(m_orph)));
`else
      check({tag, "_stat_pkts"},     64'(stat_pkts),     64'(0));
      check({tag, "_stat_trunc"},    64'(stat_trunc),    64'(0));
      check({tag, "_stat_oversize"}, 64'(stat_oversize), 64'(0));
      check({tag, "_stat_orphan"},   64'(stat_orphan),   64'(0));
`endif
   endtask

   function automatic void push_beat(input bit sop, input bit eop, input int empty, input int ierr);
      in_beat_t b;
      b.data  = $urandom;
      b.sop   = sop;
      b.eop   = eop;
      b.empty = EMPTY_W'(empty);
      b.ierr  = IN_ERR_W'(ierr);
      stim_q.push_back(b);
   endfunction

   function automatic void push_pkt(input int n, input int empty, input int err_beat);
      for (int i = 0; i < n; i++)
         push_beat(i == 0, i == n - 1, (i == n - 1) ? empty : 0, (i == err_beat) ? 1 : 0);
   endfunction

   function automatic out_beat_t dut_out();
      out_beat_t b;
      b.data  = out_data;
      b.sop   = out_startofpacket;
      b.eop   = out_endofpacket;
      b.empty = out_empty;
      b.oerr  = out_error;
      return b;
   endfunction

   in_beat_t  cur;
   bit        cur_v;
   bit        stall_p;
   out_beat_t stall_b;
   int        acc_cnt;

   task automatic cycle(input int vprob, input int rprob);
      out_beat_t ob;
      bit        acc;
      @(negedge clk);
      if (!cur_v && stim_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
         cur   = stim_q.pop_front();
         cur_v = 1'b1;
      end
      in_valid         = cur_v;
      in_data          = cur.data;
      in_startofpacket = cur.sop;
      in_endofpacket   = cur.eop;
      in_empty         = cur.empty;
      in_error         = cur.ierr;
      out_ready        = (int'($urandom_range(99)) < rprob);
      #1;
      ob = dut_out();
      if (stall_p) check("stall_stable", 64'({out_valid, ob}), 64'({1'b1, stall_b}));
      stall_p = out_valid && !out_ready;
      stall_b = ob;
      if (out_valid && out_ready) obs_q.push_back(ob);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
         model_accept(cur);
         cur_v = 1'b0;
         acc_cnt++;
      end
      while (obs_q.size() > 0 && exp_q.size() > 0)
         check("beat", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 300;
      while ((stim_q.size() > 0 || cur_v) && budget > 0) begin
         cycle(100, 100);
         budget--;
      end
      repeat (4) cycle(100, 100);
      check({tag, "_in_budget"}, 64'(budget > 0), 64'(1));
      check({tag, "_exp_left"},  64'(exp_q.size()), 64'(0));
      check({tag, "_obs_left"},  64'(obs_q.size()), 64'(0));
      check_stats(tag);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      pkt_q.delete();
      stim_q.delete();
      exp_q.delete();
      obs_q.delete();
      in_pkt  = 1'b0;
      cur_v   = 1'b0;
      stall_p = 1'b0;
      m_pkts  = 0;
      m_trunc = 0;
      m_ovs   = 0;
      m_orph  = 0;
   endtask

   initial begin
      int budget;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0;
      in_endofpacket = 1'b0; in_empty = '0; in_error = '0; out_ready = 1'b0;
      cur = '0; cur_v = 1'b0; stall_p = 1'b0; stall_b = '0; acc_cnt = 0;
      in_pkt = 1'b0; m_pkts = 0; m_trunc = 0; m_ovs = 0; m_orph = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_beat",  64'(dut_out()), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check_stats("rst");
      @(negedge clk);
      reset = 1'b0;

      push_pkt(4, 2, -1);
      drain("pkt4_clean");

      push_pkt(4, 2, 1);
      drain("pkt4_err");

      push_beat(1, 0, 1, 0);
      push_beat(0, 0, 3, 0);
      push_beat(1, 0, 0, 0);
      push_beat(0, 1, 1, 0);
      drain("trunc");

      push_pkt(6, 1, -1);
      push_pkt(5, 0, 4);
      push_pkt(4, 3, -1);
      drain("oversize");

      push_beat(0, 0, 0, 0);
      push_beat(0, 1, 0, 2);
      push_beat(1, 1, 2, 0);
      drain("orphan");

      push_beat(1, 0, 0, 0);
      push_beat(1, 1, 1, 3);
      drain("trunc_sop_eop");

      acc_cnt = 0;
      push_pkt(3, 1, -1);
      repeat (5) cycle(100, 0);
      check("bp_accepts", 64'(acc_cnt),  64'(2));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      drain("backpressure");

      push_pkt(3, 0, -1);
      stim_q.pop_back();
      repeat (4) cycle(100, 0);
      check("pre_rst_out_valid", 64'(out_valid), 64'(1));
      apply_reset();
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready",  64'(in_ready),  64'(1));
      check_stats("midrst");
      @(negedge clk);
      reset = 1'b0;
      push_pkt(2, 1, 0);
      drain("post_rst");

      for (int i = 0; i < 20; i++) push_beat(0, 0, 0, 0);
      drain("orphan_sat");

      for (int i = 0; i < 400; i++)
         push_beat($urandom_range(99) < 25, $urandom_range(99) < 25, int'($urandom_range(3)),
                   ($urandom_range(99) < 15) ? int'($urandom_range(3, 1)) : 0);
      push_beat(1, 1, 0, 0);
      budget = 4000;
      while (stim_q.size() > 0 && budget > 0) begin
         cycle(70, 60);
         budget--;
      end
      check("rand_in_budget", 64'(budget > 0), 64'(1));
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
